// File: rtl/seg7_bcd_scan_counter.sv
// rtl/seg7_bcd_scan_counter.sv - multi-digit BCD up/down counter with multiplexed 7-segment driver
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-high reset
//   i_en     count prescaler enable (scan always runs)
//   i_up     count direction, 1 = up, 0 = down
//   i_clr    synchronous clear of count value and prescaler
//   o_seg    segments {a,b,c,d,e,f,g,dp}, active-high
//   o_dig    digit enables, active-low one-hot, bit 0 = least significant digit
//   o_value  BCD count, digit k at [4k+3:4k]
//   o_wrap   one-cycle pulse when the count wraps around
module seg7_bcd_scan_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int COUNT_DIV  = 27_000_000,
    parameter int SCAN_DIV   = 27_000,
    parameter int LZ_BLANK   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_up,
    input  logic                    i_clr,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_dig,
    output logic [4*NUM_DIGITS-1:0] o_value,
    output logic                    o_wrap
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]              presc_q;
    logic [SW-1:0]              scan_q;
    logic [IW-1:0]              idx_q;
    logic                       step;
    logic [4*NUM_DIGITS-1:0]    value_next;
    logic                       chain;
    logic [3:0]                 d;
    logic [NUM_DIGITS:0]        zero_from;
    logic [3:0]                 sel_digit;
    logic                       sel_blank;

    function automatic logic [7:0] seg_encode(input logic [3:0] v);
        case (v)
            4'd0:    seg_encode = 8'b11111100;
            4'd1:    seg_encode = 8'b01100000;
            4'd2:    seg_encode = 8'b11011010;
            4'd3:    seg_encode = 8'b11110010;
            4'd4:    seg_encode = 8'b01100110;
            4'd5:    seg_encode = 8'b10110110;
            4'd6:    seg_encode = 8'b10111110;
            4'd7:    seg_encode = 8'b11100000;
            4'd8:    seg_encode = 8'b11111110;
            4'd9:    seg_encode = 8'b11110110;
            default: seg_encode = 8'b00000000;
        endcase
    endfunction

    // A step is the last prescaler cycle while enabled; clear overrides it.
    assign step = i_en && (presc_q == PRESC_MAX) && !i_clr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc_q <= '0;
        end else if (i_clr) begin
            presc_q <= '0;
        end else if (i_en) begin
            if (presc_q == PRESC_MAX) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    // BCD ripple: the carry/borrow walks up from digit 0 and stops at the
    // first digit that does not roll over. A carry out of the top digit
    // means every digit rolled over, i.e. a wrap.
    always_comb begin
        value_next = o_value;
        chain      = 1'b1;
        d          = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            d = o_value[4*k +: 4];
            if (chain) begin
                if (i_up) begin
                    if (d == 4'd9) begin
                        value_next[4*k +: 4] = 4'd0;
                    end else begin
                        value_next[4*k +: 4] = d + 4'd1;
                        chain = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        value_next[4*k +: 4] = 4'd9;
                    end else begin
                        value_next[4*k +: 4] = d - 4'd1;
                        chain = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_value <= '0;
            o_wrap  <= 1'b0;
        end else if (i_clr) begin
            o_value <= '0;
            o_wrap  <= 1'b0;
        end else if (step) begin
            o_value <= value_next;
            o_wrap  <= chain;
        end else begin
            o_wrap  <= 1'b0;
        end
    end

    // Digit scan runs independently of the count enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else if (scan_q == SCAN_MAX) begin
            scan_q <= '0;
            if (idx_q == IDX_MAX) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + IW'(1);
            end
        end else begin
            scan_q <= scan_q + SW'(1);
        end
    end

    // zero_from[k] is set when digits k..NUM_DIGITS-1 are all zero.
    always_comb begin
        zero_from             = '0;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_from[k] = (o_value[4*k +: 4] == 4'd0) && zero_from[k+1];
        end
    end

    always_comb begin
        sel_digit = 4'd0;
        sel_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                sel_digit = o_value[4*k +: 4];
                sel_blank = (LZ_BLANK != 0) && (k != 0) && zero_from[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dig <= ~NUM_DIGITS'(1);
            o_seg <= 8'b11111100;
        end else begin
            o_dig <= ~(NUM_DIGITS'(1) << idx_q);
            o_seg <= sel_blank ? 8'b00000000 : seg_encode(sel_digit);
        end
    end

endmodule

// File: tb/tb_seg7_bcd_scan_counter.sv
// tb/tb_seg7_bcd_scan_counter.sv - scoreboard bench for seg7_bcd_scan_counter
module tb_seg7_bcd_scan_counter;

    localparam int ND = 3;
    localparam int CD = 4;
    localparam int SD = 2;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_en  = 1'b0;
    logic          i_up  = 1'b1;
    logic          i_clr = 1'b0;
    logic [7:0]    o_seg, o_seg_nb;
    logic [ND-1:0] o_dig, o_dig_nb;
    logic [11:0]   o_value, o_value_nb;
    logic          o_wrap, o_wrap_nb;

    seg7_bcd_scan_counter #(.NUM_DIGITS(ND), .COUNT_DIV(CD), .SCAN_DIV(SD), .LZ_BLANK(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_up(i_up), .i_clr(i_clr),
        .o_seg(o_seg), .o_dig(o_dig), .o_value(o_value), .o_wrap(o_wrap)
    );

    seg7_bcd_scan_counter #(.NUM_DIGITS(ND), .COUNT_DIV(CD), .SCAN_DIV(SD), .LZ_BLANK(0)) dut_nb (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_up(i_up), .i_clr(i_clr),
        .o_seg(o_seg_nb), .o_dig(o_dig_nb), .o_value(o_value_nb), .o_wrap(o_wrap_nb)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [11:0] value;
        logic        wrap;
        logic [2:0]  dig;
        logic [7:0]  seg;
        logic [7:0]  seg_nb;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state: integer count, not BCD.
    int m_val, m_presc, m_scan, m_idx;

    logic [7:0] enc_tab [10];

    initial begin
        enc_tab[0] = 8'b11111100; enc_tab[1] = 8'b01100000;
        enc_tab[2] = 8'b11011010; enc_tab[3] = 8'b11110010;
        enc_tab[4] = 8'b01100110; enc_tab[5] = 8'b10110110;
        enc_tab[6] = 8'b10111110; enc_tab[7] = 8'b11100000;
        enc_tab[8] = 8'b11111110; enc_tab[9] = 8'b11110110;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] model_seg(input int v, input int idx, input bit lz);
        int p = pow10(idx);
        if (lz && idx > 0 && v < p) return 8'h00;
        return enc_tab[(v / p) % 10];
    endfunction

    task automatic model_reset();
        m_val = 0; m_presc = 0; m_scan = 0; m_idx = 0;
    endtask

    // Predict the outputs after the next edge, push, clock, pop, compare.
    task automatic tick();
        exp_t e, g;
        bit   stp;
        e.dig    = ~(3'b001 << m_idx);
        e.seg    = model_seg(m_val, m_idx, 1'b1);
        e.seg_nb = model_seg(m_val, m_idx, 1'b0);
        stp = i_en && (m_presc == CD - 1) && !i_clr;
        e.wrap = 1'b0;
        if (i_clr) begin
            m_val = 0; m_presc = 0;
        end else begin
            if (i_en) m_presc = (m_presc == CD - 1) ? 0 : m_presc + 1;
            if (stp) begin
                if (i_up) begin
                    e.wrap = (m_val == 999);
                    m_val  = (m_val + 1) % 1000;
                end else begin
                    e.wrap = (m_val == 0);
                    m_val  = (m_val + 999) % 1000;
                end
            end
        end
        e.value = to_bcd(m_val);
        if (m_scan == SD - 1) begin
            m_scan = 0;
            m_idx  = (m_idx == ND - 1) ? 0 : m_idx + 1;
        end else begin
            m_scan++;
        end
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
        g = exp_q.pop_front();
        check("value", 32'(o_value), 32'(g.value));
        check("wrap", 32'(o_wrap), 32'(g.wrap));
        check("dig", 32'(o_dig), 32'(g.dig));
        check("seg", 32'(o_seg), 32'(g.seg));
        check("seg_nb", 32'(o_seg_nb), 32'(g.seg_nb));
    endtask

    task automatic run_to(input int target, input int limit);
        int n = 0;
        while (m_val != target && n < limit) begin
            tick();
            n++;
        end
        check("reach", 32'(o_value), 32'(to_bcd(target)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value"}, 32'(o_value), 32'h000);
        check({tag, "_wrap"}, 32'(o_wrap), 32'h0);
        check({tag, "_dig"}, 32'(o_dig), 32'b110);
        check({tag, "_seg"}, 32'(o_seg), 32'hFC);
    endtask

    int wraps;

    initial begin
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("rst");
        @(negedge i_clk);
        i_rst = 1'b0;

        // 1: count up through a digit-0 carry
        i_en = 1'b1; i_up = 1'b1;
        repeat (40) tick();
        check("cnt10", 32'(o_value), 32'h010);

        // 2: wrap up at 999 and back down through 000
        run_to(999, 5000);
        wraps = 0;
        repeat (CD) begin tick(); wraps += o_wrap; end
        check("wrap_up_val", 32'(o_value), 32'h000);
        check("wrap_up_cnt", 32'(wraps), 32'd1);
        i_up = 1'b0;
        wraps = 0;
        repeat (CD) begin tick(); wraps += o_wrap; end
        check("wrap_dn_val", 32'(o_value), 32'h999);
        check("wrap_dn_cnt", 32'(wraps), 32'd1);

        // 3: blanking of leading zeros at 007
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        i_up = 1'b1;
        run_to(7, 200);
        i_en = 1'b0;
        repeat (8) tick();
        i_en = 1'b1;

        // 4: inner zero stays visible at 105
        run_to(105, 1000);
        i_en = 1'b0;
        repeat (8) tick();

        // 5: frozen count, then clear colliding with a step
        repeat (20) tick();
        check("frozen", 32'(o_value), 32'h105);
        i_en = 1'b1;
        for (int n = 0; n < CD && m_presc != CD - 1; n++) tick();
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        check("clr_step", 32'(o_value), 32'h000);
        repeat (3) tick();
        check("clr_presc", 32'(o_value), 32'h000);
        tick();
        check("clr_first", 32'(o_value), 32'h001);

        // 6: asynchronous reset at 042 while digit 2 is scanned
        run_to(42, 400);
        for (int n = 0; n < 2 * ND * SD && m_idx != 2; n++) tick();
        tick();
        #4;
        i_rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        i_rst = 1'b0;
        model_reset();
        repeat (CD - 1) tick();
        check("arst_nostep", 32'(o_value), 32'h000);
        tick();
        check("arst_step", 32'(o_value), 32'h001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
